alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu1bit.sv | 30 +++
 rtl/alu_serial_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_serial_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: opcode and controller state enums.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } alu_state_e;

  function automatic logic is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice; SUB inverts b so that a - b = a + ~b + 1 with cin seeded to 1.
module alu1bit
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_e op,
  output logic    s,
  output logic    cout
);

  logic bx;

  always_comb begin
    bx   = b ^ (op == OP_SUB);
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        s    = a ^ bx ^ cin;
        cout = (a & bx) | (a & cin) | (bx & cin);
      end
      OP_AND:  s = a & b;
      OP_OR:   s = a | b;
      default: s = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: WIDTH-bit op through one alu1bit slice, LSB first.
// Optional signed-overflow flag is built only when ALU_SERIAL_OVF_EN is defined.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output alu_state_e       dbg_state_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted only on an edge where the state is IDLE or
  // DONE; done is a one-cycle pulse marking result/cout/ovf valid, and those
  // stay held until the cycle after the next accepted start.
  alu_state_e       state_q;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q;
  logic             slice_s, slice_cout, cout_d;
  alu_op_e          op_in;

  assign op_in  = alu_op_e'(op);
  assign cout_d = is_arith(op_q) & slice_cout;

  alu1bit u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

`ifdef ALU_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
  // In the MSB cycle carry_q is the carry into the MSB.
  assign ovf_d = is_arith(op_q) & (carry_q ^ slice_cout);
  assign ovf   = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            op_q    <= op_in;
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= (op_in == OP_SUB);
            busy_q  <= 1'b1;
            cout_q  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          res_q   <= {slice_s, res_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= cout_d;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = res_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl (WIDTH=8); ovf expectations follow ALU_SERIAL_OVF_EN.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = 8;
`ifdef ALU_SERIAL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   op;
  logic [W-1:0] a, b, result;
  logic         busy, done, cout, ovf;
  alu_state_e   dbg_state;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: whole-word arithmetic, packed as {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c, v;
    full = '0; r = '0; c = 1'b0; v = 1'b0;
    case (o)
      2'b00: begin
        full = {1'b0, x} + {1'b0, y};
        r = full[W-1:0];
        c = full[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      2'b01: begin
        r = x - y;
        c = (x >= y);
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      2'b10: r = x & y;
      default: r = x | y;
    endcase
    return {v & OVF_EN, c, r};
  endfunction

  // monitor
  always @(negedge clk) begin : monitor
    logic [W+1:0] e;
    int           ec;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("result", 64'(result), 64'(e[W-1:0]));
        chk("cout", 64'(cout), 64'(e[W]));
        chk("ovf", 64'(ovf), 64'(e[W+1]));
        chk("done_cycle", 64'(cyc), 64'(ec));
        chk("busy_at_done", 64'(busy), 64'(0));
      end
    end
  end

  // driver: returns at the negedge of the last RUN cycle
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push, input int glitch, input bit rel_rst);
    @(negedge clk);
    if (rel_rst) rst = 1'b0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    if (push) begin
      exp_q.push_back(model(o, x, y));
      exp_cyc_q.push_back(cyc + W + 1);
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    chk("busy_in_run", 64'(busy), 64'(1));
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      start = (i == glitch);
      if (i == glitch) begin
        a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_result"}, 64'(result), 64'(0));
    chk({tag, "_cout"}, 64'(cout), 64'(0));
    chk({tag, "_ovf"}, 64'(ovf), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // directed cases; first one releases reset on the same negedge
    issue(2'b00, 8'h7F, 8'h01, 1'b1, -1, 1'b1); idle(2);
    issue(2'b00, 8'hFF, 8'h01, 1'b1, -1, 1'b0); idle(1);
    issue(2'b01, 8'h05, 8'h07, 1'b1, -1, 1'b0); idle(1);
    issue(2'b01, 8'h07, 8'h05, 1'b1, -1, 1'b0); idle(1);
    issue(2'b10, 8'hF0, 8'h3C, 1'b1, -1, 1'b0);
    issue(2'b11, 8'hF0, 8'h3C, 1'b1, -1, 1'b0); idle(2);
    issue(2'b00, 8'h12, 8'h34, 1'b1, 3, 1'b0); idle(1);

    // reset in RUN cycle 4 aborts the op without a done pulse
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'h55; b = 8'h66;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("midrun_rst");
    repeat (3) @(negedge clk);
    chk_zero("held_rst");
    issue(2'b01, 8'h80, 8'h01, 1'b1, -1, 1'b1); idle(1);

    // random traffic, including back-to-back and ignored mid-RUN starts
    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom), W'($urandom), W'($urandom), 1'b1,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : -1, 1'b0);
      idle($urandom_range(0, 2));
    end
    start = 1'b0;

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
    end
    idle(W + 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
